serial_adder: RTL and testbench

- Bit-serial, LSB-first WIDTH-bit adder: the additive counterpart of the team's full-subtractor datapath.
- Accepts operands A, B and carry-in over a valid/ready input handshake.
- Computes one bit per clock through a single registered-carry full-adder cell, then presents the sum and carry-out over a valid/ready output handshake.
- Sits in the arithmetic datapath where area matters more than latency.

---
 rtl/serial_arith_pkg.sv | 17 +
 rtl/serial_adder_fa_cell.sv | 15 +
 rtl/serial_adder.sv | 146 ++++++++++++++
 tb/tb_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath blocks.
// Contents: FSM state encoding (IDLE/RUN/DONE) and a helper that sizes the
// bit counter so it can reach WIDTH-1 without wrapping.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: one extra bit beyond $clog2 so WIDTH-1 never aliases.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder, dataflow style.
// Ports: a_i, b_i, ci_i (operand bits and carry-in) -> s_o (sum), co_o (carry-out).
// Latency: none (pure combinational); no handshake.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first WIDTH-bit adder with one registered-carry full-adder cell.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + a, b, cin operand handshake;
//   out_valid/out_ready + sum, cout result handshake; busy (RUN or DONE);
//   ovf (signed overflow) present only when SERIAL_ADDER_OVF_EN is defined.
// Latency: accept at cycle T -> out_valid at T+WIDTH+1; result held in DONE until out_ready.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  // Holds the WIDTH-1 low sum bits; the final bit comes straight from the
  // cell on the last RUN cycle, so the full sum is {fa_s, sum_sh_q}.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_cat;
  logic             last_bit;

  fa_cell u_fa (
    .a_i  (shift_a_q[0]),
    .b_i  (shift_b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  assign sum_cat  = {fa_s, sum_sh_q};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_a_d = a;
          shift_b_d = b;
          carry_d   = cin;
          sum_sh_d  = '0;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        sum_sh_d  = sum_cat[WIDTH-1:1];
        carry_d   = fa_co;
        cnt_d     = cnt_q + CW'(1);
        if (last_bit) begin
          // Result ports only change here, so they stay stable through DONE
          // and keep their value after the output handshake.
          sum_d   = sum_cat;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this cycle.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed vectors with hand-computed results,
// scoreboard queue filled on input handshake and drained by an output monitor.
// Build with SERIAL_ADDER_OVF_EN defined to also check the ovf port.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  // a, b, cin, expected sum, cout, ovf (all hand-computed)
  localparam int NV = 14;
  localparam vec_t VECS [NV] = '{
    {8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1},
    {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    {8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
    {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    {8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
    {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
    {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
    {8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0},
    {8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0},
    {8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0},
    {8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0},
    {8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0},
    {8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0},
    {8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;
  int   out_hs   = 0;
  bit   sends_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic send(input vec_t v);
    bit   got = 1'b0;
    exp_t e;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.sum  = v.sum;
        e.cout = v.cout;
        e.ovf  = v.ovf;
        sb_q.push_back(e);
        accepted++;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    // Output monitor: pops the scoreboard on every output handshake.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          exp_t e;
          out_hs++;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got sum=%0h cout=%0b expected no result", sum, cout);
          end else begin
            e = sb_q.pop_front();
`ifdef SERIAL_ADDER_OVF_EN
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
              errors++;
              $display("FAIL result: got sum=%0h cout=%0b ovf=%0b expected sum=%0h cout=%0b ovf=%0b",
                       sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
`else
            if (sum !== e.sum || cout !== e.cout) begin
              errors++;
              $display("FAIL result: got sum=%0h cout=%0b expected sum=%0h cout=%0b",
                       sum, cout, e.sum, e.cout);
            end
`endif
          end
        end
      end
    join_none

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency and busy window: accept at T, out_valid at T+W+1.
    out_ready = 1'b1;
    send(VECS[0]);
    begin
      int n = 0;
      bit busy_ok = 1'b1;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (!busy) busy_ok = 1'b0;
        if (out_valid) break;
        @(posedge clk);
      end
      check("latency", 64'(n), 64'(W + 1));
      check("busy_window", 64'(busy_ok), 64'd1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Directed table with random input gaps and random output backpressure.
    fork
      begin
        for (int i = 0; i < NV; i++) begin
          send(VECS[i]);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        sends_done = 1'b1;
      end
      begin
        for (int i = 0; i < 5000; i++) begin
          @(posedge clk);
          #1;
          if (sends_done && sb_q.size() == 0) break;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Backpressure: result held while out_ready=0; operands in DONE ignored.
    out_ready = 1'b0;
    send(VECS[0]);
    begin
      int n = 0;
      while (n < 40 && !out_valid) begin
        @(negedge clk);
        n++;
      end
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    a = 8'h11;
    b = 8'h22;
    cin = 1'b0;
    in_valid = 1'b1;
    begin
      bit stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (sum !== 8'h96 || cout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1)
          stable = 1'b0;
        @(posedge clk);
        #1;
      end
      check("bp_stable", 64'(stable), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_sum_retained", 64'(sum), 64'h96);
    @(posedge clk);
    #1;
    drain();

    // Reset mid-run aborts the operation.
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("abort_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(VECS[7]);
    drain();

    check("handshake_count", 64'(out_hs), 64'(accepted));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
